// File: rtl/bcd_countdown_ctrl.sv
// BCD countdown timer core: loads a validated multi-digit BCD preset, counts it
// down at a prescaled tick rate with pause/clear, and pulses done or err.
module bcd_countdown_ctrl #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            state
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          cur, nxt;
  logic [W-1:0]    count, count_nxt, count_dec;
  logic [PW-1:0]   pre, pre_nxt;
  logic            done_r, done_nxt;
  logic            err_r, err_nxt;
  logic            preset_ok;

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (borrow) begin
        if (v[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign count_dec = bcd_dec(count);
  assign preset_ok = bcd_valid(preset);

  always_comb begin
    nxt       = cur;
    count_nxt = count;
    pre_nxt   = pre;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (clear) begin
      nxt       = IDLE;
      count_nxt = '0;
      pre_nxt   = '0;
    end else begin
      case (cur)
        IDLE, DONE: begin
          if (start) begin
            if (!preset_ok) begin
              err_nxt = 1'b1;
            end else if (preset == '0) begin
              count_nxt = '0;
              nxt       = DONE;
              done_nxt  = 1'b1;
            end else begin
              count_nxt = preset;
              pre_nxt   = '0;
              nxt       = RUN;
            end
          end
        end
        // The resume edge out of PAUSED also counts, so each paused cycle costs exactly one cycle.
        RUN, PAUSED: begin
          if (pause) begin
            nxt = PAUSED;
          end else begin
            nxt = RUN;
            if (pre == PS_LAST) begin
              pre_nxt   = '0;
              count_nxt = count_dec;
              if (count_dec == '0) begin
                nxt      = DONE;
                done_nxt = 1'b1;
              end
            end else begin
              pre_nxt = pre + 1'b1;
            end
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= IDLE;
      count  <= '0;
      pre    <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      cur    <= nxt;
      count  <= count_nxt;
      pre    <= pre_nxt;
      done_r <= done_nxt;
      err_r  <= err_nxt;
    end
  end

  assign bcd_out = count;
  assign busy    = (cur == RUN) || (cur == PAUSED);
  assign done    = done_r;
  assign err     = err_r;
  assign state   = cur;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Bench for bcd_countdown_ctrl: two instances (2 digits /4, 3 digits /1) checked
// every cycle against an integer-count model plus directed literal expectations.
module tb_bcd_countdown_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st_in [2];
  logic        pa_in [2];
  logic        cl_in [2];
  logic [15:0] pr_in [2];
  logic [7:0]  bcd_a;
  logic [11:0] bcd_b;
  logic        busy_o [2];
  logic        done_o [2];
  logic        err_o  [2];
  logic [1:0]  state_o [2];

  localparam int DG [2] = '{2, 3};
  localparam int PS [2] = '{4, 1};

  int errors = 0;
  int checks = 0;

  bcd_countdown_ctrl #(.DIGITS(2), .PRESCALE(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(st_in[0]), .pause(pa_in[0]), .clear(cl_in[0]),
    .preset(pr_in[0][7:0]), .bcd_out(bcd_a), .busy(busy_o[0]), .done(done_o[0]),
    .err(err_o[0]), .state(state_o[0])
  );

  bcd_countdown_ctrl #(.DIGITS(3), .PRESCALE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(st_in[1]), .pause(pa_in[1]), .clear(cl_in[1]),
    .preset(pr_in[1][11:0]), .bcd_out(bcd_b), .busy(busy_o[1]), .done(done_o[1]),
    .err(err_o[1]), .state(state_o[1])
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: the count is a plain integer; state is 0 idle, 1 run, 2 paused, 3 done.
  int m_cnt [2];
  int m_pre [2];
  int m_st  [2];
  bit m_done [2];
  bit m_err  [2];

  function automatic int bcd2int(logic [15:0] v, int nd);
    int r = 0;
    for (int d = nd - 1; d >= 0; d--) begin
      if (v[4*d +: 4] > 4'd9) return -1;
      r = r * 10 + int'(v[4*d +: 4]);
    end
    return r;
  endfunction

  function automatic int int2bcd(int v);
    int r = 0;
    for (int d = 0; d < 4; d++) begin
      r = r | ((v % 10) << (4 * d));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void step(int i, logic s, logic p, logic c, logic [15:0] pr);
    int v;
    m_done[i] = 1'b0;
    m_err[i]  = 1'b0;
    if (c) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_st[i] = 0;
    end else if ((m_st[i] == 0 || m_st[i] == 3) && s) begin
      v = bcd2int(pr, DG[i]);
      if (v < 0) m_err[i] = 1'b1;
      else if (v == 0) begin m_cnt[i] = 0; m_st[i] = 3; m_done[i] = 1'b1; end
      else begin m_cnt[i] = v; m_pre[i] = 0; m_st[i] = 1; end
    end else if (m_st[i] == 1 || m_st[i] == 2) begin
      if (p) m_st[i] = 2;
      else begin
        m_st[i] = 1;
        m_pre[i] = m_pre[i] + 1;
        if (m_pre[i] == PS[i]) begin
          m_pre[i] = 0;
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) begin m_st[i] = 3; m_done[i] = 1'b1; end
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_st[i] = 0; m_done[i] = 1'b0; m_err[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) step(i, st_in[i], pa_in[i], cl_in[i], pr_in[i]);
    end
  end

  function automatic void cmp(int i, int bcd);
    chk($sformatf("m%0d_bcd", i), bcd, int2bcd(m_cnt[i]));
    chk($sformatf("m%0d_state", i), int'(state_o[i]), m_st[i]);
    chk($sformatf("m%0d_busy", i), int'(busy_o[i]), int'(m_st[i] == 1 || m_st[i] == 2));
    chk($sformatf("m%0d_done", i), int'(done_o[i]), int'(m_done[i]));
    chk($sformatf("m%0d_err", i), int'(err_o[i]), int'(m_err[i]));
    chk($sformatf("m%0d_excl", i), int'(done_o[i] & err_o[i]), 0);
  endfunction

  always @(negedge clk) begin
    cmp(0, int'(bcd_a));
    cmp(1, int'(bcd_b));
  end

  task automatic go(int i, logic [15:0] p);
    pr_in[i] = p;
    st_in[i] = 1'b1;
    @(negedge clk);
    st_in[i] = 1'b0;
  endtask

  initial begin
    int c;
    for (int i = 0; i < 2; i++) begin
      st_in[i] = 1'b0; pa_in[i] = 1'b0; cl_in[i] = 1'b0; pr_in[i] = '0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_bcd", int'(bcd_a), 0);
    chk("rst_state", int'(state_o[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal countdown 19 -> 00 with the 10 -> 09 borrow
    go(0, 16'h19);
    chk("load_bcd", int'(bcd_a), 'h19);
    chk("load_state", int'(state_o[0]), 1);
    c = 0;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (c == 3)  chk("hold_19", int'(bcd_a), 'h19);
      if (c == 4)  chk("tick_18", int'(bcd_a), 'h18);
      if (c == 36) chk("at_10", int'(bcd_a), 'h10);
      if (c == 40) chk("borrow_09", int'(bcd_a), 'h09);
      if (done_o[0]) break;
    end
    chk("done_latency", c, 76);
    chk("done_state", int'(state_o[0]), 3);
    @(negedge clk);
    chk("done_width", int'(done_o[0]), 0);

    // Pause for ten edges at 15
    go(0, 16'h19);
    c = 0;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (c == 16) begin chk("pause_at15", int'(bcd_a), 'h15); pa_in[0] = 1'b1; end
      if (c == 21) begin
        chk("paused_state", int'(state_o[0]), 2);
        chk("paused_busy", int'(busy_o[0]), 1);
      end
      if (c == 26) begin chk("paused_hold", int'(bcd_a), 'h15); pa_in[0] = 1'b0; end
      if (done_o[0]) break;
    end
    chk("pause_latency", c, 86);

    // Invalid and zero presets
    cl_in[0] = 1'b1; @(negedge clk); cl_in[0] = 1'b0;
    chk("clr_idle", int'(state_o[0]), 0);
    go(0, 16'h1A);
    chk("inv_err", int'(err_o[0]), 1);
    chk("inv_state", int'(state_o[0]), 0);
    @(negedge clk);
    chk("inv_err_width", int'(err_o[0]), 0);
    go(0, 16'h00);
    chk("zero_state", int'(state_o[0]), 3);
    chk("zero_done", int'(done_o[0]), 1);
    @(negedge clk);
    chk("zero_done_width", int'(done_o[0]), 0);

    // Clear during RUN, start ignored in RUN, clear beats start
    cl_in[0] = 1'b1; @(negedge clk); cl_in[0] = 1'b0;
    go(0, 16'h09);
    c = 0;
    while (c < 8) begin
      @(negedge clk);
      c++;
      if (c == 3) begin pr_in[0] = 16'h55; st_in[0] = 1'b1; end
      if (c == 4) begin
        st_in[0] = 1'b0;
        chk("run_ign_start", int'(bcd_a), 'h08);
      end
    end
    chk("pre_clear", int'(bcd_a), 'h07);
    cl_in[0] = 1'b1;
    @(negedge clk);
    cl_in[0] = 1'b0;
    chk("clear_bcd", int'(bcd_a), 0);
    chk("clear_state", int'(state_o[0]), 0);
    chk("clear_nodone", int'(done_o[0]), 0);
    cl_in[0] = 1'b1; st_in[0] = 1'b1; pr_in[0] = 16'h33;
    @(negedge clk);
    cl_in[0] = 1'b0; st_in[0] = 1'b0;
    chk("clr_start_state", int'(state_o[0]), 0);
    chk("clr_start_bcd", int'(bcd_a), 0);
    repeat (5) @(negedge clk);

    // Wide borrow on the three-digit, prescale-1 instance
    go(1, 16'h100);
    chk("w_load", int'(bcd_b), 'h100);
    @(negedge clk);
    chk("w_099", int'(bcd_b), 'h099);
    @(negedge clk);
    chk("w_098", int'(bcd_b), 'h098);
    c = 2;
    while (c < 300) begin
      if (done_o[1]) break;
      @(negedge clk);
      c++;
    end
    chk("w_latency", c, 100);

    // Asynchronous reset between edges mid-run
    go(0, 16'h19);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bcd", int'(bcd_a), 0);
    chk("arst_state", int'(state_o[0]), 0);
    chk("arst_busy", int'(busy_o[0]), 0);
    chk("arst_done", int'(done_o[0]), 0);
    chk("arst_err", int'(err_o[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
